// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle MIPS-subset control FSM with retired-instruction counter
// State, latched op/func and counter are registered; datapath controls decode combinationally from them.
module multicycle_control #(
  parameter int ALUOP_W = 4,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         opcode,
  input  logic [5:0]         func,
  input  logic               zero_flag,
  input  logic               mem_ready,
  output logic               regdst,
  output logic               regwrite,
  output logic               extop,
  output logic               alusrc,
  output logic [ALUOP_W-1:0] aluop,
  output logic               memread,
  output logic               memwrite,
  output logic               mem2reg,
  output logic               irwrite,
  output logic               pcwrite,
  output logic [1:0]         pcsrc,
  output logic               illegal,
  output logic [3:0]         state,
  output logic [CNT_W-1:0]   retired
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    EXEC_R   = 4'd2,
    EXEC_I   = 4'd3,
    MEM_ADDR = 4'd4,
    MEM_RD   = 4'd5,
    MEM_WR   = 4'd6,
    WB_ALU   = 4'd7,
    WB_MEM   = 4'd8,
    BRANCH   = 4'd9,
    JUMP     = 4'd10
  } state_t;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_J    = 6'h02;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  state_t           state_q, state_d;
  logic [5:0]       op_q, op_d;
  logic [5:0]       func_q, func_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             dec_r_ok;
  logic             dec_illegal;
  logic [3:0]       alu_r;

  // Decode looks at the live instruction bits; only DECODE acts on it.
  always_comb begin
    dec_r_ok    = (opcode == OP_R) &&
                  (func inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT});
    dec_illegal = !(dec_r_ok ||
                    (opcode inside {OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J}));
  end

  always_comb begin
    case (func_q)
      FN_SUB:  alu_r = ALU_SUB;
      FN_AND:  alu_r = ALU_AND;
      FN_OR:   alu_r = ALU_OR;
      FN_SLT:  alu_r = ALU_SLT;
      default: alu_r = ALU_ADD;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    func_d    = func_q;
    retired_d = retired_q;
    case (state_q)
      FETCH:  if (mem_ready) state_d = DECODE;
      DECODE: begin
        op_d   = opcode;
        func_d = func;
        if (dec_illegal) begin
          state_d = FETCH;
        end else begin
          case (opcode)
            OP_ADDI:       state_d = EXEC_I;
            OP_LW, OP_SW:  state_d = MEM_ADDR;
            OP_BEQ, OP_BNE: state_d = BRANCH;
            OP_J:          state_d = JUMP;
            default:       state_d = EXEC_R;
          endcase
        end
      end
      EXEC_R, EXEC_I: state_d = WB_ALU;
      MEM_ADDR:       state_d = (op_q == OP_LW) ? MEM_RD : MEM_WR;
      MEM_RD:         if (mem_ready) state_d = WB_MEM;
      MEM_WR:         if (mem_ready) state_d = FETCH;
      default:        state_d = FETCH;
    endcase
    // An instruction retires when its final step hands control back to FETCH.
    if (state_d == FETCH && state_q != FETCH && state_q != DECODE)
      retired_d = retired_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FETCH;
      op_q      <= '0;
      func_q    <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      func_q    <= func_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    regdst   = 1'b0;
    regwrite = 1'b0;
    extop    = 1'b0;
    alusrc   = 1'b0;
    aluop    = '0;
    memread  = 1'b0;
    memwrite = 1'b0;
    mem2reg  = 1'b0;
    irwrite  = 1'b0;
    pcwrite  = 1'b0;
    pcsrc    = 2'b00;
    illegal  = 1'b0;
    case (state_q)
      FETCH: begin
        memread = 1'b1;
        irwrite = mem_ready && rst_n;
        pcwrite = mem_ready && rst_n;
      end
      DECODE:   illegal = dec_illegal;
      EXEC_R:   aluop = ALUOP_W'(alu_r);
      EXEC_I, MEM_ADDR: begin
        alusrc = 1'b1;
        extop  = 1'b1;
        aluop  = ALUOP_W'(ALU_ADD);
      end
      MEM_RD:   memread = 1'b1;
      MEM_WR:   memwrite = 1'b1;
      WB_ALU: begin
        regwrite = 1'b1;
        regdst   = (op_q == OP_R);
      end
      WB_MEM: begin
        regwrite = 1'b1;
        mem2reg  = 1'b1;
      end
      BRANCH: begin
        aluop   = ALUOP_W'(ALU_SUB);
        pcsrc   = 2'b01;
        pcwrite = (op_q == OP_BEQ) ? zero_flag : !zero_flag;
      end
      JUMP: begin
        pcwrite = 1'b1;
        pcsrc   = 2'b10;
      end
      default: ;
    endcase
  end

  assign state   = state_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - directed and randomized bench for multicycle_control
// A step-plan reference model predicts every output each cycle; directed sequences pin literal values.
`timescale 1ns/1ps
module tb_multicycle_control;

  localparam int AW = 5;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [5:0]    opcode;
  logic [5:0]    func;
  logic          zero_flag;
  logic          mem_ready;
  logic          regdst, regwrite, extop, alusrc;
  logic [AW-1:0] aluop;
  logic          memread, memwrite, mem2reg, irwrite, pcwrite;
  logic [1:0]    pcsrc;
  logic          illegal;
  logic [3:0]    state;
  logic [CW-1:0] retired;

  int vectors = 0;
  int misses  = 0;

  multicycle_control #(.ALUOP_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .func(func),
    .zero_flag(zero_flag), .mem_ready(mem_ready),
    .regdst(regdst), .regwrite(regwrite), .extop(extop), .alusrc(alusrc),
    .aluop(aluop), .memread(memread), .memwrite(memwrite), .mem2reg(mem2reg),
    .irwrite(irwrite), .pcwrite(pcwrite), .pcsrc(pcsrc), .illegal(illegal),
    .state(state), .retired(retired)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      misses++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Instruction class: 0 unsupported, 1 R-type, 2 addi, 3 lw, 4 sw, 5 beq, 6 bne, 7 j
  function automatic int kind_of(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'h00:   return (fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A}) ? 1 : 0;
      6'h08:   return 2;
      6'h23:   return 3;
      6'h2B:   return 4;
      6'h04:   return 5;
      6'h05:   return 6;
      6'h02:   return 7;
      default: return 0;
    endcase
  endfunction

  // Remaining steps after DECODE, one nibble each, lowest first; an empty nibble means FETCH.
  function automatic logic [11:0] plan_of(input int k);
    case (k)
      1:       return 12'h072;
      2:       return 12'h073;
      3:       return 12'h854;
      4:       return 12'h064;
      5, 6:    return 12'h009;
      7:       return 12'h00A;
      default: return 12'h000;
    endcase
  endfunction

  function automatic logic [3:0] alu_of(input logic [5:0] fn);
    case (fn)
      6'h24:   return 4'd0;
      6'h25:   return 4'd1;
      6'h22:   return 4'd6;
      6'h2A:   return 4'd7;
      default: return 4'd2;
    endcase
  endfunction

  logic [11:0]   m_plan = '0;
  int            m_kind = 0;
  logic [5:0]    m_fn   = '0;
  logic [CW-1:0] m_ret  = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_plan <= '0;
      m_kind <= 0;
      m_fn   <= '0;
      m_ret  <= '0;
    end else if (m_plan[3:0] == 4'd0) begin
      if (mem_ready) m_plan <= 12'h001;
    end else if (m_plan[3:0] == 4'd1) begin
      m_kind <= kind_of(opcode, func);
      m_fn   <= func;
      m_plan <= plan_of(kind_of(opcode, func));
    end else if (!((m_plan[3:0] == 4'd5 || m_plan[3:0] == 4'd6) && !mem_ready)) begin
      m_plan <= m_plan >> 4;
      if (m_plan[7:4] == 4'd0) m_ret <= m_ret + 1'b1;
    end
  end

  logic          e_regdst, e_regwrite, e_extop, e_alusrc;
  logic [AW-1:0] e_aluop;
  logic          e_memread, e_memwrite, e_mem2reg, e_irwrite, e_pcwrite, e_illegal;
  logic [1:0]    e_pcsrc;

  always @(negedge clk) begin
    #1;
    e_regdst = 0; e_regwrite = 0; e_extop = 0; e_alusrc = 0; e_aluop = '0;
    e_memread = 0; e_memwrite = 0; e_mem2reg = 0; e_irwrite = 0; e_pcwrite = 0;
    e_pcsrc = 2'b00; e_illegal = 0;
    case (m_plan[3:0])
      4'd0: begin
        e_memread = 1;
        e_irwrite = mem_ready && rst_n;
        e_pcwrite = mem_ready && rst_n;
      end
      4'd1: e_illegal = (kind_of(opcode, func) == 0);
      4'd2: e_aluop = AW'(alu_of(m_fn));
      4'd3, 4'd4: begin e_alusrc = 1; e_extop = 1; e_aluop = AW'(2); end
      4'd5: e_memread = 1;
      4'd6: e_memwrite = 1;
      4'd7: begin e_regwrite = 1; e_regdst = (m_kind == 1); end
      4'd8: begin e_regwrite = 1; e_mem2reg = 1; end
      4'd9: begin
        e_aluop = AW'(6); e_pcsrc = 2'b01;
        e_pcwrite = (m_kind == 5) ? zero_flag : !zero_flag;
      end
      4'd10: begin e_pcwrite = 1; e_pcsrc = 2'b10; end
      default: ;
    endcase
    chk("state", state, m_plan[3:0]);
    chk("retired", retired, m_ret);
    chk("regdst", regdst, e_regdst);
    chk("regwrite", regwrite, e_regwrite);
    chk("extop", extop, e_extop);
    chk("alusrc", alusrc, e_alusrc);
    chk("aluop", aluop, e_aluop);
    chk("memread", memread, e_memread);
    chk("memwrite", memwrite, e_memwrite);
    chk("mem2reg", mem2reg, e_mem2reg);
    chk("irwrite", irwrite, e_irwrite);
    chk("pcwrite", pcwrite, e_pcwrite);
    chk("pcsrc", pcsrc, e_pcsrc);
    chk("illegal", illegal, e_illegal);
  end

  task automatic drive(input logic rn, input logic [5:0] op, input logic [5:0] fn,
                       input logic z, input logic mr);
    @(negedge clk);
    rst_n = rn; opcode = op; func = fn; zero_flag = z; mem_ready = mr;
    #1;
  endtask

  logic [5:0] ops [8] = '{6'h00, 6'h08, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h00};
  logic [5:0] fns [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
  int         jseq[5] = '{1, 2, 3, 0, 1};

  initial begin
    rst_n = 0; opcode = '0; func = '0; zero_flag = 0; mem_ready = 1;

    drive(0, 6'h00, 6'h00, 0, 1);
    chk("lit_rst_state", state, 0);
    chk("lit_rst_memread", memread, 1);
    chk("lit_rst_irwrite", irwrite, 0);
    chk("lit_rst_retired", retired, 0);

    // add
    drive(1, 6'h00, 6'h00, 0, 1);
    chk("lit_add_fetch_ir", irwrite, 1);
    drive(1, 6'h00, 6'h20, 0, 0);
    chk("lit_add_decode", state, 1);
    drive(1, 6'h3F, 6'h3F, 0, 1);
    chk("lit_add_exec", state, 2);
    chk("lit_add_aluop", aluop, 2);
    drive(1, 6'h00, 6'h00, 0, 1);
    chk("lit_add_wb", state, 7);
    chk("lit_add_regdst", regdst, 1);
    chk("lit_add_ret0", retired, 0);
    drive(1, 6'h00, 6'h00, 0, 0);
    chk("lit_add_ret1", retired, 1);

    // lw with three wait cycles
    drive(1, 6'h00, 6'h00, 0, 1);
    drive(1, 6'h23, 6'h00, 0, 0);
    drive(1, 6'h00, 6'h00, 0, 0);
    chk("lit_lw_addr", state, 4);
    for (int i = 0; i < 4; i++) begin
      drive(1, 6'h00, 6'h00, 0, (i == 3));
      chk("lit_lw_memread", {state, memread}, {4'd5, 1'b1});
    end
    drive(1, 6'h00, 6'h00, 0, 0);
    chk("lit_lw_wbmem", {state, mem2reg, regwrite}, {4'd8, 2'b11});
    drive(1, 6'h00, 6'h00, 0, 0);
    chk("lit_lw_ret", retired, 2);

    // beq taken, bne not taken
    drive(1, 6'h00, 6'h00, 0, 1);
    drive(1, 6'h04, 6'h00, 0, 0);
    drive(1, 6'h00, 6'h00, 1, 0);
    chk("lit_beq", {state, pcwrite, pcsrc}, {4'd9, 1'b1, 2'b01});
    drive(1, 6'h00, 6'h00, 0, 1);
    drive(1, 6'h05, 6'h00, 0, 0);
    drive(1, 6'h00, 6'h00, 1, 0);
    chk("lit_bne", {state, pcwrite}, {4'd9, 1'b0});
    drive(1, 6'h00, 6'h00, 0, 0);
    chk("lit_branch_ret", retired, 0);

    // unsupported opcode
    drive(1, 6'h00, 6'h00, 0, 1);
    drive(1, 6'h3F, 6'h00, 0, 0);
    chk("lit_ill_pulse", illegal, 1);
    chk("lit_ill_we", {regwrite, memwrite, pcwrite, irwrite}, 0);
    drive(1, 6'h00, 6'h00, 0, 0);
    chk("lit_ill_back", {state, illegal}, 0);
    chk("lit_ill_ret", retired, 0);

    // five jumps wrap the 2-bit counter
    for (int i = 0; i < 5; i++) begin
      drive(1, 6'h00, 6'h00, 0, 1);
      if (i > 0) chk("lit_j_ret", retired, jseq[i-1]);
      drive(1, 6'h02, 6'h00, 0, 0);
      drive(1, 6'h00, 6'h00, 0, 0);
      chk("lit_j", {state, pcwrite, pcsrc}, {4'd10, 1'b1, 2'b10});
    end
    drive(1, 6'h00, 6'h00, 0, 0);
    chk("lit_j_ret", retired, jseq[4]);

    // sw aborted by reset during the memory wait
    drive(1, 6'h00, 6'h00, 0, 1);
    drive(1, 6'h2B, 6'h00, 0, 0);
    drive(1, 6'h00, 6'h00, 0, 0);
    drive(1, 6'h00, 6'h00, 0, 0);
    chk("lit_sw_wait", {state, memwrite}, {4'd6, 1'b1});
    drive(0, 6'h00, 6'h00, 0, 0);
    chk("lit_sw_abort", {state, memwrite, memread}, {4'd0, 1'b0, 1'b1});
    chk("lit_sw_ret", retired, 0);
    drive(0, 6'h00, 6'h00, 0, 1);

    for (int i = 0; i < 2500; i++) begin
      logic [5:0] op, fn;
      op = ($urandom_range(0, 9) < 8) ? ops[$urandom_range(0, 7)] : 6'($urandom);
      fn = ($urandom_range(0, 4) != 0) ? fns[$urandom_range(0, 4)] : 6'($urandom);
      drive($urandom_range(0, 299) != 0, op, fn, 1'($urandom), $urandom_range(0, 2) != 0);
    end
    drive(1, 6'h00, 6'h00, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter ALUOP_W, default 4: width of aluop; legal values are 4 or more.
REQ-002 Parameter CNT_W, default 16: width of the retired-instruction counter.
REQ-003 clk  input  1  system clock; all state changes occur on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 opcode  input  6  instruction bits [31:26]; sampled only in DECODE.
REQ-006 func  input  6  instruction bits [5:0]; sampled only in DECODE.
REQ-007 zero_flag  input  1  ALU zero result; used only in BRANCH.
REQ-008 mem_ready  input  1  memory handshake; the current memory access completes on a cycle where this is 1.
REQ-009 regdst, regwrite, extop, alusrc  output  1 each  datapath controls; extop=1 selects sign-extend.
REQ-010 aluop  output  ALUOP_W  ALU code: and=0000, or=0001, add=0010, sub=0110, slt=0111, zero-extended to ALUOP_W.
REQ-011 memread, memwrite, mem2reg, irwrite, pcwrite  output  1 each  memory and PC/IR controls; mem2reg=1 selects memory data.
REQ-012 pcsrc  output  2  next-PC select: 00=PC+4, 01=branch target, 10=jump target.
REQ-013 illegal  output  1  one-cycle pulse on an unsupported opcode/func.
REQ-014 state  output  4  current state encoding, for debug.
REQ-015 retired  output  CNT_W  count of completed legal instructions.

Function
REQ-016 Controller SHALL be a registered FSM with states FETCH=0, DECODE=1, EXEC_R=2, EXEC_I=3, MEM_ADDR=4, MEM_RD=5, MEM_WR=6, WB_ALU=7, WB_MEM=8, BRANCH=9, JUMP=10.
REQ-017 Outputs SHALL be combinational from state, latched op/func and, in BRANCH only, zero_flag; every output not listed for a state SHALL be 0.
REQ-018 FETCH: memread=1; when mem_ready=1, irwrite=1, pcwrite=1 and pcsrc=00, then go to DECODE; otherwise stay in FETCH.
REQ-019 DECODE: SHALL latch opcode/func, assert no write enables, and last exactly one cycle.
REQ-020 DECODE SHALL go to EXEC_R for R-type (op 000000) with func add 100000, sub 100010, and 100100, or 100101, or slt 101010.
REQ-021 DECODE SHALL go to EXEC_I for addi (001000), to MEM_ADDR for lw (100011) or sw (101011), to BRANCH for beq (000100) or bne (000101), and to JUMP for j (000010).
REQ-022 Any other op/func in DECODE SHALL pulse illegal=1 for that cycle and return to FETCH, with no write enable asserted and retired unchanged.
REQ-023 EXEC_R: aluop SHALL be set from func per REQ-010, alusrc=0; next state WB_ALU.
REQ-024 EXEC_I: alusrc=1, extop=1, aluop=add; next state WB_ALU.
REQ-025 WB_ALU: regwrite=1, mem2reg=0, regdst=1 for R-type and 0 for addi; next state FETCH.
REQ-026 MEM_ADDR: alusrc=1, extop=1, aluop=add; next state MEM_RD for lw, MEM_WR for sw.
REQ-027 MEM_RD: memread=1, held until mem_ready=1, then go to WB_MEM.
REQ-028 WB_MEM: regwrite=1, mem2reg=1, regdst=0; next state FETCH.
REQ-029 MEM_WR: memwrite=1, held until mem_ready=1, then go to FETCH.
REQ-030 BRANCH: aluop=sub, alusrc=0, pcsrc=01; pcwrite=zero_flag for beq and pcwrite=!zero_flag for bne; next state FETCH.
REQ-031 JUMP: pcwrite=1, pcsrc=10; next state FETCH.
REQ-032 retired SHALL increment by 1, wrapping modulo 2^CNT_W, on every transition into FETCH except from DECODE.
REQ-033 A taken or untaken branch SHALL count as retired.
REQ-034 mem_ready=1 outside FETCH, MEM_RD and MEM_WR SHALL be ignored.

Reset
REQ-035 While rst_n=0: state=FETCH, latched op/func=0, retired=0, outputs per FETCH with mem_ready=0 (memread=1, all others 0, illegal=0).
REQ-036 Reset asserted in any state, including mid-wait in MEM_RD or MEM_WR, SHALL abort the instruction immediately without incrementing retired.
REQ-037 The first FETCH after rst_n rises SHALL start on the next rising edge.

Verification
REQ-038 add (op 000000, func 100000), mem_ready=1 in FETCH -> states 0,1,2,7,0; WB_ALU regwrite=1, regdst=1; retired 0->1.
REQ-039 lw with mem_ready low 3 cycles in MEM_RD -> memread held 3+1 cycles; WB_MEM mem2reg=1, regwrite=1; 6 states total plus wait cycles.
REQ-040 beq with zero_flag=1, then bne with zero_flag=1 -> pcwrite=1 with pcsrc=01 for the first, pcwrite=0 for the second; retired increments by 2.
REQ-041 Opcode 111111 -> illegal pulses one cycle in DECODE, return to FETCH, retired unchanged, no write enables asserted.
REQ-042 sw with rst_n dropped during MEM_WR wait -> state=FETCH asynchronously, memwrite=0, retired=0.
REQ-043 CNT_W=2, five j instructions -> pcsrc=10 and pcwrite=1 in each JUMP; retired sequence 1,2,3,0,1.
